tape_ram: RTL and testbench

TAPE_RAM -- requirements
Module: tape_ram

---
 rtl/tape_ram.sv | 234 +++++++++++++++++++++++
 tb/tb_tape_ram.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tape_ram.sv
// -----------------------------------------------------------------------------
// tape_ram
//   Single-port word RAM fronted by a small command FSM. One request is
//   accepted at a time. READ and WRITE complete in one cycle. INC and DEC do a
//   read-modify-write and complete in two cycles. CLEAR walks every address,
//   writing one zero word per cycle. Illegal ops and out-of-range addresses
//   complete in one cycle with err set.
//
//   Optional feature macro: TAPE_RAM_RMW_EN
//     defined   -> INC (op 2) / DEC (op 3) are implemented, including the RMW
//                  state and its adder.
//     undefined -> op 2 / op 3 are illegal ops. There is no RMW state and no
//                  adder.
//
// Parameters
//   WIDTH : data word width in bits (1..32)
//   DEPTH : number of words (2..4096); AW = $clog2(DEPTH)
//
// Ports
//   clk   in   single clock, rising edge
//   rstb  in   synchronous active-low reset (memory contents are kept)
//   req   in   request valid; taken only while busy is low
//   op    in   0 READ, 1 WRITE, 2 INC, 3 DEC, 4 CLEAR, 5-7 illegal
//   addr  in   word address (ignored for CLEAR)
//   wdata in   write data for WRITE
//   rdata out  registered result word
//   ack   out  one-cycle completion pulse
//   busy  out  high from the cycle after acceptance through the ack cycle
//   err   out  one-cycle error pulse, coincident with ack
// -----------------------------------------------------------------------------
module tape_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ack,
  output logic             busy,
  output logic             err
);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
`ifdef TAPE_RAM_RMW_EN
  localparam logic [2:0] OP_INC   = 3'd2;
  localparam logic [2:0] OP_DEC   = 3'd3;
`endif
  localparam logic [2:0] OP_CLEAR = 3'd4;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef TAPE_RAM_RMW_EN
    RMW  = 2'd1,
`endif
    CLR  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Storage. It starts at zero and is never touched by reset.
  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  state_t           state_q;
  logic [WIDTH-1:0] rdata_q;
  logic             ack_q;
  logic             busy_q;
  logic             err_q;
  logic [AW-1:0]    clr_cnt_q;

`ifdef TAPE_RAM_RMW_EN
  logic [WIDTH-1:0] rmw_val_q;   // word read at acceptance
  logic [AW-1:0]    rmw_addr_q;  // address to write back
  logic             rmw_dec_q;   // 1 = DEC, 0 = INC
  logic [WIDTH-1:0] rmw_d;       // modified word, wraps modulo 2^WIDTH

  assign rmw_d = rmw_dec_q ? (rmw_val_q - WIDTH'(1)) : (rmw_val_q + WIDTH'(1));
`endif

  // An address can only be out of range when DEPTH is not a power of two.
  logic addr_ok;
  generate
    if (DEPTH == (1 << AW)) begin : gen_addr_full
      assign addr_ok = 1'b1;
    end else begin : gen_addr_chk
      assign addr_ok = (addr < AW'(DEPTH));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Memory write port. Every write is gated by rstb, so a reset edge that
  // lands mid-CLEAR or mid-RMW drops the write of that cycle.
  // ---------------------------------------------------------------------------
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (rstb) begin
      case (state_q)
        IDLE: begin
          if (req && (op == OP_WRITE) && addr_ok) begin
            mem_we = 1'b1;
          end
        end
`ifdef TAPE_RAM_RMW_EN
        RMW: begin
          mem_we    = 1'b1;
          mem_waddr = rmw_addr_q;
          mem_wdata = rmw_d;
        end
`endif
        CLR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_cnt_q;
          mem_wdata = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      // ack and err are single-cycle pulses unless set again below.
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            busy_q <= 1'b1;
            case (op)
              OP_READ: begin
                state_q <= DONE;
                ack_q   <= 1'b1;
                if (addr_ok) begin
                  rdata_q <= mem_q[addr];
                end else begin
                  err_q <= 1'b1;
                end
              end
              OP_WRITE: begin
                // The memory write itself happens in the write-port logic.
                state_q <= DONE;
                ack_q   <= 1'b1;
                err_q   <= !addr_ok;
              end
`ifdef TAPE_RAM_RMW_EN
              OP_INC, OP_DEC: begin
                if (addr_ok) begin
                  state_q    <= RMW;
                  rmw_val_q  <= mem_q[addr];
                  rmw_addr_q <= addr;
                  rmw_dec_q  <= op[0];
                end else begin
                  state_q <= DONE;
                  ack_q   <= 1'b1;
                  err_q   <= 1'b1;
                end
              end
`endif
              OP_CLEAR: begin
                state_q   <= CLR;
                clr_cnt_q <= '0;
              end
              default: begin
                // Illegal op: complete at once with an error, no memory access.
                state_q <= DONE;
                ack_q   <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end
        end
`ifdef TAPE_RAM_RMW_EN
        RMW: begin
          state_q <= DONE;
          ack_q   <= 1'b1;
          rdata_q <= rmw_d;
        end
`endif
        CLR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        DONE: begin
          // The ack cycle; requests are accepted again from the next cycle.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_tape_ram.sv
// -----------------------------------------------------------------------------
// tb_tape_ram
//   Directed bench for tape_ram. It uses two instances that share op, addr and
//   wdata:
//     dut_a : WIDTH=8, DEPTH=16 (power-of-two depth)
//     dut_b : WIDTH=8, DEPTH=10 (addresses 10..15 are out of range)
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tape_ram;

  localparam int TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rstb;
  logic [2:0] op;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       req_a, req_b;
  logic [7:0] rdata_a, rdata_b;
  logic       ack_a, busy_a, err_a;
  logic       ack_b, busy_b, err_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tape_ram #(.WIDTH(8), .DEPTH(16)) dut_a (
    .clk(clk), .rstb(rstb), .req(req_a), .op(op), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a), .err(err_a)
  );

  tape_ram #(.WIDTH(8), .DEPTH(10)) dut_b (
    .clk(clk), .rstb(rstb), .req(req_b), .op(op), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Results of the most recent transaction.
  int         lat;        // cycles from acceptance edge to ack (1 = T+1)
  int         busy_cnt;   // cycles with busy high, T+1 .. ack cycle
  logic [7:0] rd;         // rdata in the ack cycle
  logic       er;         // err in the ack cycle
  logic       ack_after;  // ack in the cycle after ack
  logic       busy_after; // busy in the cycle after ack
  logic       err_after;  // err in the cycle after ack

  // Issue one request. The caller is just past a falling edge; the task
  // returns just past the falling edge of the cycle after ack.
  task automatic txn(input bit sel, input logic [2:0] o, input logic [3:0] a,
                     input logic [7:0] d);
    op    = o;
    addr  = a;
    wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(negedge clk);
    req_a    = 1'b0;
    req_b    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (1) begin
      if ((sel ? busy_b : busy_a) === 1'b1) busy_cnt++;
      if ((sel ? ack_b : ack_a) === 1'b1 || lat >= TIMEOUT) break;
      @(negedge clk);
      lat++;
    end
    rd = sel ? rdata_b : rdata_a;
    er = sel ? err_b : err_a;
    @(negedge clk);
    ack_after  = sel ? ack_b : ack_a;
    busy_after = sel ? busy_b : busy_a;
    err_after  = sel ? err_b : err_a;
    $display("txn dut=%s op=%0d addr=%0d wdata=%02h lat=%0d busy=%0d rdata=%02h err=%b",
             sel ? "b" : "a", o, a, d, lat, busy_cnt, rd, er);
  endtask

  task automatic read_chk(input bit sel, input logic [3:0] a, input logic [7:0] exp,
                          input string tag);
    txn(sel, 3'd0, a, 8'h00);
    check(tag, rd, exp);
  endtask

  logic seen_ack;

  initial begin
    rstb  = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    op    = 3'd0;
    addr  = 4'd0;
    wdata = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rdata", rdata_a, 8'h00);
    check("rst_ack",   ack_a,   1'b0);
    check("rst_busy",  busy_a,  1'b0);
    check("rst_err",   err_a,   1'b0);
    check("rst_b_busy", busy_b, 1'b0);
    rstb = 1'b1;
    @(negedge clk);

    // READ after reset
    txn(0, 3'd0, 4'd5, 8'h00);
    check("rd5_lat",   lat, 1);
    check("rd5_rdata", rd,  8'h00);
    check("rd5_err",   er,  1'b0);
    check("rd5_busy_cnt", busy_cnt, 1);
    check("rd5_busy_after", busy_after, 1'b0);

    // WRITE then READ, one-cycle acks
    txn(0, 3'd1, 4'd3, 8'hA5);
    check("wr3_lat",   lat, 1);
    check("wr3_err",   er,  1'b0);
    check("wr3_rdata_unchanged", rd, 8'h00);
    check("wr3_ack_one_cycle", ack_after, 1'b0);
    txn(0, 3'd0, 4'd3, 8'h00);
    check("rd3_lat",   lat, 1);
    check("rd3_rdata", rd,  8'hA5);
    check("rd3_ack_one_cycle", ack_after, 1'b0);

    // INC / DEC wrap around
    txn(0, 3'd1, 4'd7, 8'hFF);
    check("wr7_err", er, 1'b0);
`ifdef TAPE_RAM_RMW_EN
    txn(0, 3'd2, 4'd7, 8'h00);
    check("inc7_lat",   lat, 2);
    check("inc7_rdata", rd,  8'h00);
    check("inc7_err",   er,  1'b0);
    txn(0, 3'd3, 4'd7, 8'h00);
    check("dec7_lat",   lat, 2);
    check("dec7_rdata", rd,  8'hFF);
    check("dec7_err",   er,  1'b0);
`else
    txn(0, 3'd2, 4'd7, 8'h00);
    check("inc7_lat", lat, 1);
    check("inc7_err", er,  1'b1);
    txn(0, 3'd3, 4'd7, 8'h00);
    check("dec7_lat", lat, 1);
    check("dec7_err", er,  1'b1);
`endif
    read_chk(0, 4'd7, 8'hFF, "rd7_after_rmw");

    // Illegal op: error pulse, no memory change
    txn(0, 3'd6, 4'd3, 8'h3C);
    check("op6_lat", lat, 1);
    check("op6_err", er,  1'b1);
    check("op6_err_one_cycle", err_after, 1'b0);
    read_chk(0, 4'd3, 8'hA5, "rd3_after_op6");

    // Request held high while busy is ignored
    op = 3'd0; addr = 4'd3; req_a = 1'b1;
    @(negedge clk);                       // T+1: ack cycle
    op = 3'd1; wdata = 8'h5A;             // req stays high during busy
    check("held_ack",   ack_a,   1'b1);
    check("held_busy",  busy_a,  1'b1);
    check("held_rdata", rdata_a, 8'hA5);
    @(negedge clk);
    req_a = 1'b0;
    check("held_busy_clear", busy_a, 1'b0);
    check("held_no_ack",     ack_a,  1'b0);
    @(negedge clk);
    check("held_still_idle", busy_a, 1'b0);
    read_chk(0, 4'd3, 8'hA5, "rd3_after_held");

    // CLEAR, full run
    for (int i = 0; i < 16; i++) txn(0, 3'd1, 4'(i), 8'(8'h10 + i));
    read_chk(0, 4'd15, 8'h1F, "fill_rd15");
    txn(0, 3'd4, 4'd9, 8'h00);
    check("clr_lat",      lat,      17);
    check("clr_busy_cnt", busy_cnt, 17);
    check("clr_rdata",    rd,       8'h00);
    check("clr_err",      er,       1'b0);
    check("clr_ack_one_cycle", ack_after, 1'b0);
    for (int i = 0; i < 16; i++) read_chk(0, 4'(i), 8'h00, $sformatf("clr_rd%0d", i));

    // CLEAR aborted by reset at T+8
    for (int i = 0; i < 16; i++) txn(0, 3'd1, 4'(i), 8'(8'hA0 + i));
    op = 3'd4; addr = 4'd0; req_a = 1'b1;
    @(negedge clk);                       // T+1
    req_a    = 1'b0;
    seen_ack = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (ack_a !== 1'b0) seen_ack = 1'b1;
      @(negedge clk);
    end                                   // now in T+8
    if (ack_a !== 1'b0) seen_ack = 1'b1;
    check("abort_busy_mid", busy_a, 1'b1);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    check("abort_no_ack", seen_ack, 1'b0);
    check("abort_ack_after_rst",  ack_a,  1'b0);
    check("abort_busy_after_rst", busy_a, 1'b0);
    for (int i = 0; i < 16; i++)
      read_chk(0, 4'(i), (i < 7) ? 8'h00 : 8'(8'hA0 + i), $sformatf("abort_rd%0d", i));

    // DEPTH=10 instance: out-of-range addresses
    txn(1, 3'd0, 4'd12, 8'h00);
    check("b_rd12_lat",   lat, 1);
    check("b_rd12_err",   er,  1'b1);
    check("b_rd12_rdata", rd,  8'h00);
    txn(1, 3'd1, 4'd9, 8'h3C);
    check("b_wr9_err", er, 1'b0);
    read_chk(1, 4'd9, 8'h3C, "b_rd9");
    txn(1, 3'd1, 4'd13, 8'h77);
    check("b_wr13_lat", lat, 1);
    check("b_wr13_err", er,  1'b1);
    txn(1, 3'd0, 4'd12, 8'h00);
    check("b_rd12_rdata_unchanged", rd, 8'h3C);
    check("b_rd12_err2", er, 1'b1);
    read_chk(1, 4'd9, 8'h3C, "b_rd9_after_bad");
    txn(1, 3'd2, 4'd15, 8'h00);
    check("b_inc15_lat", lat, 1);
    check("b_inc15_err", er,  1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
